// File: rtl/rtc_access_sequencer.sv
// RTC register access sequencer: an init write sweep, then read/write bursts separated by a refresh gap.
// Optional macro SEQ_TIMEOUT_EN adds an io_done watchdog that raises err and restarts initialisation.
module rtc_access_sequencer #(
  parameter int unsigned       ADDR_W      = 8,
  parameter int unsigned       INIT_COUNT  = 9,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(8'h21),
  parameter int unsigned       BURST_LEN   = 9,
  parameter int unsigned       REFRESH_DIV = 1000,
  parameter int unsigned       TIMEOUT_CYC = 4096
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic              mode_wr,
  input  logic              io_done,
  output logic              wr_start,
  output logic              rd_start,
  output logic [ADDR_W-1:0] addr,
  output logic              init_phase,
  output logic              init_done,
  output logic              burst_done,
  output logic              busy,
  output logic              err
);

  localparam int unsigned XFER_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned GAP_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [ADDR_W-1:0] INIT_LAST = ADDR_W'(INIT_COUNT - 1);
  localparam logic [XFER_W-1:0] XFER_LAST = XFER_W'(BURST_LEN - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(REFRESH_DIV - 1);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    INIT_ISSUE = 4'd1,
    INIT_WAIT  = 4'd2,
    DECIDE     = 4'd3,
    RD_ISSUE   = 4'd4,
    RD_WAIT    = 4'd5,
    WR_ISSUE   = 4'd6,
    WR_WAIT    = 4'd7,
    GAP        = 4'd8
  } state_t;

  state_t            state_r;
  logic [XFER_W-1:0] xfer_cnt_r;
  logic [GAP_W-1:0]  gap_cnt_r;
  logic              in_wait_s;
  logic              timeout_s;

  assign in_wait_s = (state_r == INIT_WAIT) || (state_r == RD_WAIT) || (state_r == WR_WAIT);

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned WAIT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

  logic [WAIT_W-1:0] wait_cnt_r;
  logic              err_r;

  assign timeout_s = in_wait_s && !io_done && (wait_cnt_r == WAIT_LAST);
  assign err       = err_r;

  // Watchdog: counts consecutive WAIT cycles without io_done; err is sticky until reset.
  always_ff @(posedge CLK) begin
    if (reset) begin
      wait_cnt_r <= {WAIT_W{1'b0}};
      err_r      <= 1'b0;
    end else begin
      if (!start || !in_wait_s || io_done || timeout_s) begin
        wait_cnt_r <= {WAIT_W{1'b0}};
      end else begin
        wait_cnt_r <= wait_cnt_r + WAIT_W'(1'b1);
      end
      if (start && timeout_s) begin
        err_r <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout_s;

  assign unused_timeout_s = (TIMEOUT_CYC != 32'd0);
  assign timeout_s        = 1'b0;
  assign err              = 1'b0;
`endif

  // Sequencer FSM; strobes trail their ISSUE state by one cycle, other flags track the state.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_r    <= IDLE;
      xfer_cnt_r <= {XFER_W{1'b0}};
      gap_cnt_r  <= {GAP_W{1'b0}};
      addr       <= {ADDR_W{1'b0}};
      wr_start   <= 1'b0;
      rd_start   <= 1'b0;
      init_phase <= 1'b0;
      init_done  <= 1'b0;
      burst_done <= 1'b0;
      busy       <= 1'b0;
    end else if (!start) begin
      state_r    <= IDLE;
      wr_start   <= 1'b0;
      rd_start   <= 1'b0;
      init_phase <= 1'b0;
      init_done  <= 1'b0;
      burst_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      wr_start   <= 1'b0;
      rd_start   <= 1'b0;
      burst_done <= 1'b0;
      case (state_r)
        IDLE: begin
          addr       <= {ADDR_W{1'b0}};
          init_phase <= 1'b1;
          busy       <= 1'b1;
          state_r    <= INIT_ISSUE;
        end
        INIT_ISSUE: begin
          wr_start <= 1'b1;
          state_r  <= INIT_WAIT;
        end
        DECIDE: begin
          addr       <= BASE_ADDR;
          xfer_cnt_r <= {XFER_W{1'b0}};
          busy       <= 1'b1;
          state_r    <= mode_wr ? WR_ISSUE : RD_ISSUE;
        end
        RD_ISSUE: begin
          rd_start <= 1'b1;
          state_r  <= RD_WAIT;
        end
        WR_ISSUE: begin
          wr_start <= 1'b1;
          state_r  <= WR_WAIT;
        end
        INIT_WAIT, RD_WAIT, WR_WAIT: begin
          if (io_done) begin
            if ((state_r == INIT_WAIT) && (addr == INIT_LAST)) begin
              init_done  <= 1'b1;
              init_phase <= 1'b0;
              busy       <= 1'b0;
              state_r    <= DECIDE;
            end else if ((state_r != INIT_WAIT) && (xfer_cnt_r == XFER_LAST)) begin
              burst_done <= 1'b1;
              busy       <= 1'b0;
              gap_cnt_r  <= {GAP_W{1'b0}};
              state_r    <= GAP;
            end else begin
              addr       <= addr + ADDR_W'(1'b1);
              xfer_cnt_r <= xfer_cnt_r + XFER_W'(1'b1);
              state_r    <= (state_r == INIT_WAIT) ? INIT_ISSUE :
                            (state_r == RD_WAIT)   ? RD_ISSUE : WR_ISSUE;
            end
          end else if (timeout_s) begin
            init_phase <= 1'b0;
            init_done  <= 1'b0;
            busy       <= 1'b0;
            state_r    <= IDLE;
          end else begin
            state_r <= state_r;
          end
        end
        GAP: begin
          if (gap_cnt_r == GAP_LAST) begin
            state_r <= DECIDE;
          end else begin
            gap_cnt_r <= gap_cnt_r + GAP_W'(1'b1);
          end
        end
        default: begin
          init_phase <= 1'b0;
          busy       <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_access_sequencer.sv
// Randomised bench for rtc_access_sequencer: a timeline reference model drives io_done and predicts every output.
// Two instances share stimulus; one uses BASE_ADDR 8'hFF to exercise address wrap.
module tb_rtc_access_sequencer;

  localparam int INIT_COUNT  = 3;
  localparam int BURST_LEN   = 2;
  localparam int REFRESH_DIV = 4;
  localparam int TIMEOUT_CYC = 16;
  localparam int DIR_CYC     = 60;
  localparam int RAND_CYC    = 3000;
`ifdef SEQ_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       reset, start, mode_wr, io_done;
  logic       wr0, rd0, ip0, id0, bd0, busy0, err0;
  logic       wr1, rd1, ip1, id1, bd1, busy1, err1;
  logic [7:0] addr0, addr1;

  always #5 CLK = ~CLK;

  rtc_access_sequencer #(.ADDR_W(8), .INIT_COUNT(INIT_COUNT), .BASE_ADDR(8'h21), .BURST_LEN(BURST_LEN),
                         .REFRESH_DIV(REFRESH_DIV), .TIMEOUT_CYC(TIMEOUT_CYC)) dut0 (
    .CLK(CLK), .reset(reset), .start(start), .mode_wr(mode_wr), .io_done(io_done),
    .wr_start(wr0), .rd_start(rd0), .addr(addr0), .init_phase(ip0), .init_done(id0),
    .burst_done(bd0), .busy(busy0), .err(err0));

  rtc_access_sequencer #(.ADDR_W(8), .INIT_COUNT(INIT_COUNT), .BASE_ADDR(8'hFF), .BURST_LEN(BURST_LEN),
                         .REFRESH_DIV(REFRESH_DIV), .TIMEOUT_CYC(TIMEOUT_CYC)) dut1 (
    .CLK(CLK), .reset(reset), .start(start), .mode_wr(mode_wr), .io_done(io_done),
    .wr_start(wr1), .rd_start(rd1), .addr(addr1), .init_phase(ip1), .init_done(id1),
    .burst_done(bd1), .busy(busy1), .err(err1));

  int vectors = 0;
  int miscompares = 0;
  int n = 0;
  bit chk_en = 1'b0;
  bit directed = 1'b1;

  // Timeline model: cycle stamps of the next ISSUE, DECIDE and current strobe.
  bit m_active, m_waiting, m_is_init, m_is_wr;
  int m_idx, m_issue_at, m_decide_at, m_strobe_cyc, m_done_at, lat_next;
  bit e_wr, e_rd, e_init_phase, e_init_done, e_burst_done, e_busy, e_err;

  typedef struct {
    int         cyc;
    bit         wr;
    logic [7:0] a0;
    logic [7:0] a1;
    bit         ip;
  } ev_t;
  ev_t evq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, n);
    end
  endtask

  function automatic logic [7:0] exp_addr(input logic [7:0] base);
    logic [7:0] t;
    t = m_is_init ? 8'(m_idx) : base + 8'(m_idx);
    return t;
  endfunction

  // Advance the model across the edge that ends cycle n, using that cycle's inputs.
  task automatic model_edge(input bit s, input bit m, input bit d);
    int c;
    c = n + 1;
    e_burst_done = 1'b0;
    if (!s) begin
      m_active = 1'b0; m_waiting = 1'b0; m_issue_at = -1; m_decide_at = -1; e_init_done = 1'b0;
    end else if (!m_active) begin
      m_active = 1'b1; m_is_init = 1'b1; m_idx = 0; m_issue_at = c; m_decide_at = -1;
    end else if (m_waiting && d) begin
      m_waiting = 1'b0;
      if (m_is_init && m_idx == INIT_COUNT - 1) begin
        e_init_done = 1'b1; m_decide_at = c;
      end else if (!m_is_init && m_idx == BURST_LEN - 1) begin
        e_burst_done = 1'b1; m_decide_at = c + REFRESH_DIV;
      end else begin
        m_idx++; m_issue_at = c;
      end
    end else if (m_waiting && TIMEOUT_ON && (n - m_strobe_cyc + 1 >= TIMEOUT_CYC)) begin
      m_active = 1'b0; m_waiting = 1'b0; e_err = 1'b1; e_init_done = 1'b0;
    end else if (m_decide_at == n) begin
      m_is_init = 1'b0; m_is_wr = m; m_idx = 0; m_issue_at = c; m_decide_at = -1;
    end else if (m_issue_at == n) begin
      m_waiting = 1'b1; m_strobe_cyc = c; m_issue_at = -1; m_done_at = c + lat_next;
    end
    e_wr         = m_waiting && (m_strobe_cyc == c) && (m_is_init || m_is_wr);
    e_rd         = m_waiting && (m_strobe_cyc == c) && !m_is_init && !m_is_wr;
    e_busy       = m_active && ((m_issue_at == c) || m_waiting);
    e_init_phase = m_active && !e_init_done;
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("wr_start0", wr0, e_wr);     chk("wr_start1", wr1, e_wr);
      chk("rd_start0", rd0, e_rd);     chk("rd_start1", rd1, e_rd);
      chk("init_phase0", ip0, e_init_phase); chk("init_phase1", ip1, e_init_phase);
      chk("init_done0", id0, e_init_done);   chk("init_done1", id1, e_init_done);
      chk("burst_done0", bd0, e_burst_done); chk("burst_done1", bd1, e_burst_done);
      chk("busy0", busy0, e_busy);     chk("busy1", busy1, e_busy);
      chk("err0", err0, e_err);        chk("err1", err1, e_err);
      if (m_waiting) begin
        chk("addr0", addr0, exp_addr(8'h21));
        chk("addr1", addr1, exp_addr(8'hFF));
      end
      if (directed) begin
        if (wr0 || rd0) evq.push_back('{cyc: n, wr: wr0, a0: addr0, a1: addr1, ip: ip0});
        if (n == 16) begin
          chk("decide_init_done", id0, 1'b1);
          chk("decide_busy", busy0, 1'b0);
        end
        if (n == 27) chk("gap_burst_done", bd0, 1'b1);
        if (n == 50) chk("drop_init_done", id0, 1'b0);
      end
    end
  end

  int         x_cyc [9] = '{2, 7, 12, 18, 23, 33, 38, 48, 55};
  bit         x_wr  [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [7:0] x_a0  [9] = '{8'h00, 8'h01, 8'h02, 8'h21, 8'h22, 8'h21, 8'h22, 8'h21, 8'h00};
  logic [7:0] x_a1  [9] = '{8'h00, 8'h01, 8'h02, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00};

  initial begin
    m_active = 1'b0; m_waiting = 1'b0; m_is_init = 1'b1; m_is_wr = 1'b0; m_idx = 0;
    m_issue_at = -1; m_decide_at = -1; m_strobe_cyc = -100; m_done_at = -1; lat_next = 3;
    e_wr = 1'b0; e_rd = 1'b0; e_init_phase = 1'b0; e_init_done = 1'b0;
    e_burst_done = 1'b0; e_busy = 1'b0; e_err = 1'b0;
    reset = 1'b1; start = 1'b0; mode_wr = 1'b0; io_done = 1'b0;
    repeat (3) @(posedge CLK);
    #1 reset = 1'b0;
    chk("reset_wr_start", wr0, 1'b0);
    chk("reset_rd_start", rd0, 1'b0);
    chk("reset_addr", addr0, 8'h00);
    chk("reset_busy", busy0, 1'b0);
    chk("reset_init_done", id0, 1'b0);
    chk("reset_err", err0, 1'b0);
    chk_en = 1'b1;

    for (int k = 0; k < DIR_CYC + RAND_CYC; k++) begin
      directed = (n < DIR_CYC);
      if (directed) begin
        start    = !(n >= 49 && n <= 52);
        mode_wr  = (n >= 20 && n < 40);
        lat_next = 3;
        io_done  = (m_waiting && n == m_done_at) || (n == 51);
      end else begin
        start    = ($urandom_range(0, 63) != 0);
        mode_wr  = 1'($urandom_range(0, 1));
        lat_next = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(1, 4));
        io_done  = m_waiting ? (n == m_done_at) : ($urandom_range(0, 3) == 0);
      end
      @(posedge CLK);
      model_edge(start, mode_wr, io_done);
      n++;
      #1;
    end
    @(negedge CLK);
    chk_en = 1'b0;

    chk("directed_strobe_count", evq.size(), 9);
    for (int i = 0; i < 9 && i < evq.size(); i++) begin
      chk($sformatf("strobe%0d_cycle", i), evq[i].cyc, x_cyc[i]);
      chk($sformatf("strobe%0d_is_wr", i), evq[i].wr, x_wr[i]);
      chk($sformatf("strobe%0d_addr21", i), evq[i].a0, x_a0[i]);
      chk($sformatf("strobe%0d_addrFF", i), evq[i].a1, x_a1[i]);
      if (i < 3) chk($sformatf("strobe%0d_init_phase", i), evq[i].ip, 1'b1);
    end
    chk("final_err", err0, 32'(TIMEOUT_ON));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rtc_access_sequencer.md
# rtc_access_sequencer

Parametrised top-level sequencer for the RTC register interface. After `start`, it runs a programmable initialisation write sweep. It then alternates between read bursts and write bursts selected by the mode switch, with a configurable refresh gap between bursts. It sits above the bus-level read/write engines and drives them through a one-cycle start pulse and a done handshake.

## Interface
Parameters:
- `ADDR_W`, 8: width of the register address bus.
- `INIT_COUNT`, 9: number of registers written during initialisation, at addresses 0 .. `INIT_COUNT`-1. Range 1 .. 2^`ADDR_W`.
- `BASE_ADDR`, 8'h21: first address of each read/write burst.
- `BURST_LEN`, 9: registers per burst. Range 1 .. 2^`ADDR_W`.
- `REFRESH_DIV`, 1000: idle cycles between the end of one burst and the next mode decision. Range ≥1.
- `TIMEOUT_CYC`, 4096: maximum wait for `io_done`. Used only with `SEQ_TIMEOUT_EN`.

Ports:
- `CLK` in 1: clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: level enable. While low, the sequencer is held in IDLE.
- `mode_wr` in 1: burst-type select; 1 = write burst, 0 = read burst.
- `io_done` in 1: one-cycle completion pulse from the bus engine.
- `wr_start` out 1: one-cycle pulse requesting a register write.
- `rd_start` out 1: one-cycle pulse requesting a register read.
- `addr` out `ADDR_W`: target register. Valid while `wr_start` or `rd_start` is high, and held during the wait.
- `init_phase` out 1: high during the initialisation sweep. The data path uses it to select init data.
- `init_done` out 1: sticky; set when initialisation completes.
- `burst_done` out 1: one-cycle pulse after the last transfer of a burst.
- `busy` out 1: high in every state except IDLE, DECIDE and GAP.
- `err` out 1: sticky timeout flag. Tied 0 when `SEQ_TIMEOUT_EN` is not defined.

## Operation
- States: IDLE, INIT_ISSUE, INIT_WAIT, DECIDE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, GAP.
- IDLE → INIT_ISSUE when `start`=1.
- INIT_ISSUE: `wr_start`=1 and `init_phase`=1; next state INIT_WAIT.
- INIT_WAIT:
  - On `io_done`, if `addr`=`INIT_COUNT`-1: set `init_done` and go to DECIDE.
  - Otherwise: `addr`+1, then INIT_ISSUE.
- DECIDE: `mode_wr` is sampled here only. 1 → WR_ISSUE, 0 → RD_ISSUE. `addr` loads `BASE_ADDR`.
- RD_ISSUE and WR_ISSUE pulse their strobe, then go to the matching WAIT state.
- In RD_WAIT and WR_WAIT, on `io_done`:
  - If the transfer count = `BURST_LEN`-1: pulse `burst_done` and go to GAP.
  - Otherwise: `addr`+1, then back to the ISSUE state.
- GAP counts `REFRESH_DIV` cycles, then returns to DECIDE.
- A change of `mode_wr` during a burst or gap takes effect at the next DECIDE.
- `io_done` is ignored outside the WAIT states, including any `io_done` in the same cycle as an ISSUE state.
- `addr` increments modulo 2^`ADDR_W`, so `BASE_ADDR`+`BURST_LEN` may wrap past the top of the address space.
- `start` falling in any state: next state IDLE. All strobes drop the same edge, `init_done` clears, and the in-flight transfer is abandoned. `err` is cleared only by `reset`.
- `reset` overrides everything: state IDLE, all outputs 0, `addr`=0, counters 0.

## Timing
- All outputs are registered and Moore-decoded from state.
- `start` sampled high at edge k → `wr_start`=1 with `addr`=0 for exactly the cycle after edge k+1.
- `io_done` sampled at edge j → the next strobe is high after edge j+1, i.e. one idle cycle between done and the next strobe.
- The `burst_done` pulse occupies the first GAP cycle.
- DECIDE lasts exactly 1 cycle.
- Burst-to-burst period = `BURST_LEN`·(2+engine latency) + `REFRESH_DIV` + 1 cycles.
- `init_done` rises in the same cycle the FSM enters DECIDE.

## Configuration
- `SEQ_TIMEOUT_EN` defined:
  - A wait counter runs in INIT_WAIT, RD_WAIT and WR_WAIT.
  - If `TIMEOUT_CYC` cycles elapse without `io_done`, the sequencer sets `err` and goes to IDLE.
  - With `start` still high, it re-runs the full initialisation from `addr` 0.
  - The counter clears on every ISSUE state.
- `SEQ_TIMEOUT_EN` not defined: the counter is absent, `err`=0 constantly, and WAIT states wait indefinitely.

## Test plan
Bench parameters: `INIT_COUNT`=3, `BASE_ADDR`=8'h21, `BURST_LEN`=2, `REFRESH_DIV`=4, and `io_done` returned 3 cycles after each strobe unless stated otherwise.
- Reset then `start`=1 → `wr_start` pulses at `addr` 0, 1, 2 with `init_phase`=1 → `init_done`=1 and `busy`=0 in DECIDE.
- `mode_wr`=0 → `rd_start` at 8'h21 then 8'h22 → `burst_done` pulse → 4 GAP cycles → next DECIDE.
- `mode_wr` toggled 0→1 mid read burst → that burst completes as reads; the next burst issues `wr_start` at 8'h21.
- `BASE_ADDR`=8'hFF, `BURST_LEN`=2 → burst addresses 8'hFF then 8'h00.
- `start` dropped while in RD_WAIT → IDLE next edge, `init_done`=0. A later `io_done` is ignored. Raising `start` restarts init at `addr` 0.
- With `SEQ_TIMEOUT_EN` and `TIMEOUT_CYC`=16, withhold `io_done` → `err`=1 after 16 wait cycles → re-init from `addr` 0. Without the macro, the FSM stays in WAIT and `err`=0.
